// File: rtl/data_mem_responder.sv
// Data-memory responder: slave end of the core's load/store port.
// Accepts one word request at a time (valid/ready), waits WAIT_CYCLES wait
// states, performs the access on the word array and holds the response until
// the requester takes it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_write                  1 = store, 0 = load
//   req_addr, req_wdata        byte address, store data
//   resp_valid / resp_ready    response handshake (valid held until taken)
//   resp_rdata                 load data; zero for stores and errors
//   resp_error                 misaligned or out-of-range request
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WaitLast = WAIT_CYCLES[3:0];
  localparam bit          NoWait   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, err_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic [31:0]           mem [Depth];

  logic                  accept;
  logic                  access_en;
  logic                  acc_write, acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;

  // Misaligned, or any address bit above the array's word index set.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_WIDTH+2] != '0);
  endfunction

  assign accept     = (state_q == StIdle) && req_valid;
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    access_en = 1'b0;
    acc_write = write_q;
    acc_err   = err_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = '0;
          if (NoWait) begin
            // Zero wait states: the access happens on the accept edge itself,
            // so it is fed straight from the request inputs.
            acc_write = req_write;
            acc_err   = addr_bad(req_addr);
            acc_idx   = req_addr[ADDR_WIDTH+1:2];
            acc_wdata = req_wdata;
            access_en = 1'b1;
            state_d   = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == WaitLast) begin
          access_en = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (access_en) begin
      error_d = acc_err;
      rdata_d = (acc_write || acc_err) ? 32'h0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= addr_bad(req_addr);
        idx_q   <= req_addr[ADDR_WIDTH+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // Array is never reset; rst_n gating drops a store that coincides with reset.
  always_ff @(posedge clk) begin
    if (rst_n && access_en && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
